memory_sequencer: RTL and testbench
===================================

Name: memory_sequencer

Overview:
- Controller that sequences SYSTEM_MEMORY_V2 by driving its LOAD_MODE, RUN_MODE and SERIAL_IN inputs.
- Accepts a serial seed pattern over a valid/ready bit stream and shifts exactly DATA_SIZE bits into the memory.
- Schedules generation updates, free-running at a fixed cadence or single-stepped, and counts the generations committed.
- Sits between the host/config interface and the memory + next-state logic of each grid row.

Parameters:
DATA_SIZE, 5, cells per row; number of bits shifted per load.
STEP_DIV, 4, clock cycles between RUN_MODE pulses in free-run (must be >= 2).
GEN_W, 16, width of the generation counter and limit.

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RESET  input  1  synchronous, active-low reset.
LOAD_REQ  input  1  start a serial load (sampled in IDLE only).
RUN_REQ  input  1  start free-running generations (sampled in IDLE only).
STEP_REQ  input  1  commit exactly one generation (sampled in IDLE only).
STOP_REQ  input  1  abort RUN and return to IDLE.
GEN_LIMIT  input  GEN_W  generations to run before auto-stop; 0 = unlimited.
BIT_IN  input  1  serial seed bit.
BIT_IN_VALID  input  1  BIT_IN is valid.
BIT_IN_READY  output  1  sequencer accepts a bit this cycle.
SERIAL_OUT  output  1  to memory SERIAL_IN.
LOAD_MODE  output  1  to memory LOAD_MODE.
RUN_MODE  output  1  to memory RUN_MODE.
LOAD_DONE  output  1  one-cycle pulse when the final load bit is issued.
BUSY  output  1  high in any state other than IDLE.
GEN_COUNT  output  GEN_W  generations committed since the last load.

Behaviour:
- Reset (RESET low at an edge): state IDLE. All outputs 0, GEN_COUNT 0, bit counter 0, divider 0. Reset has priority over every other input and aborts any load or run in progress. Partially shifted memory contents are left as-is.
- States: IDLE, LOAD, RUN, STEP. Outputs are registered except BIT_IN_READY, which is combinational: 1 exactly when state == LOAD.
- IDLE:
  - Request priority when several requests are high: LOAD_REQ > RUN_REQ > STEP_REQ.
  - LOAD_REQ: go to LOAD; clear bit counter and GEN_COUNT.
  - RUN_REQ: go to RUN; clear divider.
  - STEP_REQ: go to STEP.
  - Requests arriving while not in IDLE are ignored; they are not queued.
- LOAD:
  - On each handshake (BIT_IN_VALID & BIT_IN_READY) at an edge: SERIAL_OUT <= BIT_IN, LOAD_MODE <= 1 for one cycle, bit counter increments.
  - With no handshake, LOAD_MODE <= 0 and SERIAL_OUT holds.
  - The handshake accepting bit DATA_SIZE: LOAD_DONE <= 1 concurrently with that final LOAD_MODE pulse, state <= IDLE, BIT_IN_READY drops the next cycle.
  - Bits are issued in arrival order. The first bit accepted ends up in the highest memory bit position after DATA_SIZE shifts.
  - STOP_REQ has no effect in LOAD.
- RUN:
  - Divider counts 0..STEP_DIV-1. At the edge where divider == STEP_DIV-1: RUN_MODE <= 1 for one cycle, GEN_COUNT += 1 (saturating at all-ones), divider <= 0.
  - The first pulse appears STEP_DIV cycles after the edge that entered RUN.
  - Auto-stop: if GEN_LIMIT != 0 and GEN_COUNT+1 == GEN_LIMIT at the pulse edge, the pulse is still issued and state <= IDLE.
  - If GEN_LIMIT != 0 and GEN_COUNT >= GEN_LIMIT on entering RUN: return to IDLE at the next edge with no pulse.
  - STOP_REQ: state <= IDLE at the next edge. It suppresses a pulse that would coincide with that edge.
  - LOAD_MODE is always 0 in RUN/STEP; the memory gives RUN_MODE priority regardless.
- STEP: RUN_MODE <= 1 for one cycle and GEN_COUNT += 1 (saturating) at the edge leaving STEP, state <= IDLE. GEN_LIMIT is ignored.
- GEN_COUNT and SERIAL_OUT hold their values in IDLE.

Decomposition:
- Package conway_ctrl_pkg holds:
  - seq_state_t enum: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, STEP=2'd3.
  - The default localparams for STEP_DIV and GEN_W.
- One sub-module, step_timer: STEP_DIV divider with clear and enable inputs and a terminal-count output. It is reused by the display refresh logic.
- Everything else (FSM, bit counter, GEN_COUNT) stays inline.

Test Plan:
- Reset mid-RUN after 2 pulses (RESET low one edge) -> next cycle: state IDLE, BUSY=0, RUN_MODE=0, GEN_COUNT=0, BIT_IN_READY=0.
- LOAD_REQ, then bits 1,0,0,1,0 with BIT_IN_VALID held high (DATA_SIZE=5) -> 5 LOAD_MODE pulses on consecutive cycles, LOAD_DONE with the 5th, memory DATA_OUT = 5'b10010, BIT_IN_READY=0 afterwards.
- Same load with BIT_IN_VALID low on alternate cycles -> LOAD_MODE pulses only after valid cycles, still exactly 5 pulses, same DATA_OUT.
- RUN_REQ with GEN_LIMIT=3, STEP_DIV=4 -> RUN_MODE pulses 4, 8 and 12 cycles after entry, GEN_COUNT 1,2,3, then IDLE and no further pulses.
- RUN_REQ with GEN_LIMIT=0, STOP_REQ asserted on the cycle before the 2nd pulse edge -> only 1 pulse, GEN_COUNT=1, IDLE.
- LOAD_REQ and RUN_REQ high together in IDLE -> enters LOAD, RUN_MODE stays 0; then STEP_REQ in IDLE -> exactly one RUN_MODE pulse, GEN_COUNT=1.

Source files
------------

// File: rtl/conway_ctrl_pkg.sv
// conway_ctrl_pkg: shared sequencer state encoding and default timing parameters
package conway_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } seq_state_t;

    localparam int STEP_DIV_DEFAULT = 4;
    localparam int GEN_W_DEFAULT    = 16;

endpackage

// File: rtl/step_timer.sv
// step_timer: modulo-DIV cadence divider with clear, enable and terminal count
module step_timer
    import conway_ctrl_pkg::*;
#(
    parameter int DIV = STEP_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tc = cnt == CW'(DIV - 1);

    // count 0..DIV-1 while enabled, wrapping on terminal count
    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/memory_sequencer.sv
// memory_sequencer: serial seed loader and generation scheduler for the row memory
module memory_sequencer
    import conway_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 5,
    parameter int STEP_DIV  = STEP_DIV_DEFAULT,
    parameter int GEN_W     = GEN_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_REQ,
    input  logic             RUN_REQ,
    input  logic             STEP_REQ,
    input  logic             STOP_REQ,
    input  logic [GEN_W-1:0] GEN_LIMIT,
    input  logic             BIT_IN,
    input  logic             BIT_IN_VALID,
    output logic             BIT_IN_READY,
    output logic             SERIAL_OUT,
    output logic             LOAD_MODE,
    output logic             RUN_MODE,
    output logic             LOAD_DONE,
    output logic             BUSY,
    output logic [GEN_W-1:0] GEN_COUNT
);

    localparam int BW = $clog2(DATA_SIZE + 1);

    seq_state_t       state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [GEN_W-1:0] gen_n, gen_inc;
    logic [GEN_W:0]   gen_plus;
    logic             serial_n, load_mode_n, run_mode_n, load_done_n;
    logic             hs, tc, limit_hit, over_limit;

    assign BIT_IN_READY = state == LOAD;
    assign hs           = BIT_IN_VALID & BIT_IN_READY;
    assign gen_plus     = {1'b0, GEN_COUNT} + (GEN_W + 1)'(1);
    assign gen_inc      = &GEN_COUNT ? GEN_COUNT : gen_plus[GEN_W-1:0];
    assign limit_hit    = GEN_LIMIT != '0 && gen_plus == {1'b0, GEN_LIMIT};
    assign over_limit   = GEN_LIMIT != '0 && GEN_COUNT >= GEN_LIMIT;

    // divider only runs in RUN and restarts from zero on every entry
    step_timer #(.DIV(STEP_DIV)) u_timer (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (state != RUN),
        .en    (state == RUN),
        .tc    (tc)
    );

    // next state and next registered outputs
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        gen_n       = GEN_COUNT;
        serial_n    = SERIAL_OUT;
        load_mode_n = 1'b0;
        run_mode_n  = 1'b0;
        load_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD_REQ) begin
                    state_n   = LOAD;
                    bit_cnt_n = '0;
                    gen_n     = '0;
                end else if (RUN_REQ) begin
                    state_n = RUN;
                end else if (STEP_REQ) begin
                    state_n = STEP;
                end
            end
            LOAD: begin
                if (hs) begin
                    serial_n    = BIT_IN;
                    load_mode_n = 1'b1;
                    bit_cnt_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_SIZE - 1)) begin
                        load_done_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            RUN: begin
                if (STOP_REQ || over_limit) begin
                    state_n = IDLE;
                end else if (tc) begin
                    run_mode_n = 1'b1;
                    gen_n      = gen_inc;
                    if (limit_hit) state_n = IDLE;
                end
            end
            STEP: begin
                run_mode_n = 1'b1;
                gen_n      = gen_inc;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            GEN_COUNT  <= '0;
            SERIAL_OUT <= 1'b0;
            LOAD_MODE  <= 1'b0;
            RUN_MODE   <= 1'b0;
            LOAD_DONE  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            GEN_COUNT  <= gen_n;
            SERIAL_OUT <= serial_n;
            LOAD_MODE  <= load_mode_n;
            RUN_MODE   <= run_mode_n;
            LOAD_DONE  <= load_done_n;
            BUSY       <= state_n != IDLE;
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// tb_memory_sequencer: randomized scoreboard bench with a transaction-level model
module tb_memory_sequencer;

    localparam int DS = 5;
    localparam int SD = 4;
    localparam int GW = 16;

    typedef struct {
        logic b;
        logic last;
    } ld_t;

    typedef struct {
        int          at;
        logic [15:0] gen;
    } rn_t;

    logic          clk, rst_n;
    logic          load_req, run_req, step_req, stop_req;
    logic [GW-1:0] gen_limit;
    logic          bit_in, bit_in_valid, bit_in_ready;
    logic          serial_out, load_mode, run_mode, load_done, busy;
    logic [GW-1:0] gen_count;

    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    int        mgen = 0;
    logic [4:0] mem_model = '0;
    ld_t       load_q[$];
    rn_t       run_q[$];
    ld_t       ld;
    rn_t       rn;

    memory_sequencer #(.DATA_SIZE(DS), .STEP_DIV(SD), .GEN_W(GW)) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .LOAD_REQ     (load_req),
        .RUN_REQ      (run_req),
        .STEP_REQ     (step_req),
        .STOP_REQ     (stop_req),
        .GEN_LIMIT    (gen_limit),
        .BIT_IN       (bit_in),
        .BIT_IN_VALID (bit_in_valid),
        .BIT_IN_READY (bit_in_ready),
        .SERIAL_OUT   (serial_out),
        .LOAD_MODE    (load_mode),
        .RUN_MODE     (run_mode),
        .LOAD_DONE    (load_done),
        .BUSY         (busy),
        .GEN_COUNT    (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every memory-facing pulse must match the head of its queue
    always @(negedge clk) begin
        if (load_mode) begin
            if (load_q.size() == 0) chk("unexpected_load_mode", 32'(load_mode), 0);
            else begin
                ld = load_q.pop_front();
                chk("serial_bit", 32'(serial_out), 32'(ld.b));
                chk("load_done", 32'(load_done), 32'(ld.last));
            end
            mem_model = {mem_model[3:0], serial_out};
        end else if (load_done) chk("stray_load_done", 32'(load_done), 0);
        if (run_mode) begin
            if (run_q.size() == 0) chk("unexpected_run_mode", 32'(run_mode), 0);
            else begin
                rn = run_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(rn.at));
                chk("gen_count", 32'(gen_count), 32'(rn.gen));
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_load(input logic [4:0] d, input int gap_mode, input bit with_run);
        int gap;
        load_req = 1'b1;
        run_req  = with_run;
        @(negedge clk);
        load_req = 1'b0;
        run_req  = 1'b0;
        mgen     = 0;
        chk("busy_in_load", 32'(busy), 1);
        chk("gen_cleared", 32'(gen_count), 0);
        for (int i = 0; i < DS; i++) begin
            gap = gap_mode == 1 ? (i > 0 ? 1 : 0) : gap_mode == 2 ? int'($urandom_range(0, 2)) : 0;
            bit_in_valid = 1'b0;
            bit_in       = $urandom;
            repeat (gap) @(negedge clk);
            chk("ready_in_load", 32'(bit_in_ready), 1);
            bit_in       = d[4-i];
            bit_in_valid = 1'b1;
            load_q.push_back('{d[4-i], i == DS - 1});
            run_req  = $urandom;
            step_req = $urandom;
            @(negedge clk);
        end
        bit_in_valid = 1'b0;
        run_req      = 1'b0;
        step_req     = 1'b0;
        chk("ready_after_load", 32'(bit_in_ready), 0);
        @(negedge clk);
        chk("busy_after_load", 32'(busy), 0);
        chk("mem_contents", 32'(mem_model), 32'(d));
        chk("load_q_drained", 32'(load_q.size()), 0);
        bit_in_valid = 1'b1;
        @(negedge clk);
        bit_in_valid = 1'b0;
        chk("ready_idle", 32'(bit_in_ready), 0);
    endtask

    task automatic do_run(input logic [15:0] lim, input int stop_p);
        int entry, n, np;
        entry     = cyc + 1;
        gen_limit = lim;
        run_req   = 1'b1;
        n  = (lim == 0) ? 1000 : (mgen >= int'(lim) ? 0 : int'(lim) - mgen);
        np = (stop_p != 0 && stop_p - 1 < n) ? stop_p - 1 : n;
        for (int j = 1; j <= np; j++) run_q.push_back('{entry + SD * j, 16'(mgen + j)});
        mgen += np;
        @(negedge clk);
        run_req = 1'b0;
        if (stop_p != 0) begin
            while (cyc < entry + SD * stop_p - 1) @(negedge clk);
            stop_req = 1'b1;
            @(negedge clk);
            stop_req = 1'b0;
        end
        wait_idle();
        repeat (SD + 1) @(negedge clk);
        chk("run_q_drained", 32'(run_q.size()), 0);
        chk("gen_after_run", 32'(gen_count), 32'(mgen));
    endtask

    task automatic do_step();
        gen_limit = 16'($urandom_range(1, 3));
        step_req  = 1'b1;
        run_q.push_back('{cyc + 2, 16'(mgen + 1)});
        mgen++;
        @(negedge clk);
        step_req = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("step_q_drained", 32'(run_q.size()), 0);
        chk("gen_after_step", 32'(gen_count), 32'(mgen));
    endtask

    initial begin
        int entry, op, lim;
        rst_n = 1'b0; load_req = 1'b0; run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
        gen_limit = '0; bit_in = 1'b0; bit_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gen", 32'(gen_count), 0);
        chk("rst_ready", 32'(bit_in_ready), 0);
        chk("rst_outs", {28'd0, serial_out, load_mode, run_mode, load_done}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(5'b10010, 0, 1'b0);
        do_load(5'b10010, 1, 1'b0);
        do_run(16'd3, 0);
        do_run(16'd3, 0);
        do_load(5'($urandom), 2, 1'b0);
        do_run(16'd0, 2);
        do_load(5'b01101, 0, 1'b1);
        do_step();

        entry     = cyc + 1;
        gen_limit = '0;
        run_req   = 1'b1;
        run_q.push_back('{entry + SD, 16'(mgen + 1)});
        run_q.push_back('{entry + 2 * SD, 16'(mgen + 2)});
        @(negedge clk);
        run_req = 1'b0;
        while (cyc < entry + 2 * SD) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mgen  = 0;
        chk("midrun_busy", 32'(busy), 0);
        chk("midrun_run_mode", 32'(run_mode), 0);
        chk("midrun_gen", 32'(gen_count), 0);
        chk("midrun_ready", 32'(bit_in_ready), 0);
        repeat (3 * SD) @(negedge clk);
        chk("midrun_q_drained", 32'(run_q.size()), 0);

        for (int it = 0; it < 25; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) do_load(5'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
            else if (op == 1) begin
                lim = $urandom_range(0, 5);
                do_run(16'(lim), lim == 0 ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 4)));
            end else do_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
